// File: rtl/ctrl_if_arb_mux.sv
// rtl/ctrl_if_arb_mux.sv - two-master control-interface arbiter and region mux
// Round-robin between m0/m1, address-decoded slave select, per-master completion with timeout.
module ctrl_if_arb_mux #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {11'h460, 11'h060, 11'h004, 11'h000},
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit AHB_CTRL_IF_EN = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ctrlSel_m0,
  input  logic                             ctrlWr_m0,
  input  logic [ADDR_WIDTH-1:0]            ctrlAddr_m0,
  input  logic [DATA_WIDTH-1:0]            ctrlWrData_m0,
  input  logic [DATA_WIDTH/8-1:0]          ctrlWrStrbs_m0,
  output logic                             ctrlWrRdy_m0,
  output logic                             ctrlRdValid_m0,
  output logic [DATA_WIDTH-1:0]            ctrlRdData_m0,
  output logic                             ctrlErr_m0,
  input  logic                             ctrlSel_m1,
  input  logic                             ctrlWr_m1,
  input  logic [ADDR_WIDTH-1:0]            ctrlAddr_m1,
  input  logic [DATA_WIDTH-1:0]            ctrlWrData_m1,
  input  logic [DATA_WIDTH/8-1:0]          ctrlWrStrbs_m1,
  output logic                             ctrlWrRdy_m1,
  output logic                             ctrlRdValid_m1,
  output logic [DATA_WIDTH-1:0]            ctrlRdData_m1,
  output logic                             ctrlErr_m1,
  output logic [NUM_SLAVES-1:0]            ctrlSel,
  output logic                             ctrlWr,
  output logic [ADDR_WIDTH-1:0]            ctrlAddr,
  output logic [DATA_WIDTH-1:0]            ctrlWrData,
  output logic [DATA_WIDTH/8-1:0]          ctrlWrStrbs,
  input  logic [NUM_SLAVES-1:0]            ctrlWrRdy_s,
  input  logic [NUM_SLAVES-1:0]            ctrlRdValid_s,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] ctrlRdData_s
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SLV_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic                   gnt_q, gnt_d;
  logic [SLV_W-1:0]       slv_q, slv_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]      strb_q, strb_d;
  logic [DATA_WIDTH-1:0]  rdata_m0_q, rdata_m0_d;
  logic [DATA_WIDTH-1:0]  rdata_m1_q, rdata_m1_d;

  logic                   req0, req1, grant_m1;
  logic                   req_wr;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic [STRB_W-1:0]      req_strb;
  logic [SLV_W-1:0]       slv_dec;
  logic [DATA_WIDTH-1:0]  slv_rdata;
  logic                   done;

  assign req0 = ctrlSel_m0;
  assign req1 = AHB_CTRL_IF_EN ? ctrlSel_m1 : 1'b0;
  // m1 wins only when m0 is idle or the round-robin pointer already favours it
  assign grant_m1  = req1 && (!req0 || ptr_q);
  assign req_wr    = grant_m1 ? ctrlWr_m1      : ctrlWr_m0;
  assign req_addr  = grant_m1 ? ctrlAddr_m1    : ctrlAddr_m0;
  assign req_wdata = grant_m1 ? ctrlWrData_m1  : ctrlWrData_m0;
  assign req_strb  = grant_m1 ? ctrlWrStrbs_m1 : ctrlWrStrbs_m0;

  always_comb begin
    slv_dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (req_addr >= SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) slv_dec = SLV_W'(i);
    end
  end

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_q == SLV_W'(i)) slv_rdata = ctrlRdData_s[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign done = wr_q ? ctrlWrRdy_s[slv_q] : ctrlRdValid_s[slv_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      slv_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_m0_q <= '0;
      rdata_m1_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      slv_q      <= slv_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      rdata_m0_q <= rdata_m0_d;
      rdata_m1_q <= rdata_m1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    slv_d      = slv_q;
    cnt_d      = '0;
    err_d      = err_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    rdata_m0_d = rdata_m0_q;
    rdata_m1_d = rdata_m1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = grant_m1;
          ptr_d   = !grant_m1;
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          strb_d  = req_strb;
          slv_d   = slv_dec;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          state_d = RESP;
          err_d   = 1'b0;
          if (!wr_q) begin
            if (gnt_q) rdata_m1_d = slv_rdata;
            else       rdata_m0_d = slv_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (!wr_q) begin
            if (gnt_q) rdata_m1_d = '0;
            else       rdata_m0_d = '0;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrlSel        = '0;
    ctrlWrRdy_m0   = 1'b0;
    ctrlRdValid_m0 = 1'b0;
    ctrlErr_m0     = 1'b0;
    ctrlWrRdy_m1   = 1'b0;
    ctrlRdValid_m1 = 1'b0;
    ctrlErr_m1     = 1'b0;
    if (state_q == ISSUE) ctrlSel[slv_q] = 1'b1;
    if (state_q == RESP) begin
      if (!gnt_q) begin
        ctrlWrRdy_m0   = wr_q;
        ctrlRdValid_m0 = !wr_q;
        ctrlErr_m0     = err_q;
      end else if (AHB_CTRL_IF_EN) begin
        ctrlWrRdy_m1   = wr_q;
        ctrlRdValid_m1 = !wr_q;
        ctrlErr_m1     = err_q;
      end
    end
  end

  assign ctrlRdData_m0 = rdata_m0_q;
  assign ctrlRdData_m1 = AHB_CTRL_IF_EN ? rdata_m1_q : '0;
  assign ctrlWr        = wr_q;
  assign ctrlAddr      = addr_q;
  assign ctrlWrData    = wdata_q;
  assign ctrlWrStrbs   = strb_q;

endmodule

// File: tb/tb_ctrl_if_arb_mux.sv
// tb/tb_ctrl_if_arb_mux.sv - directed self-checking bench for ctrl_if_arb_mux
module tb_ctrl_if_arb_mux;

  logic         clock = 1'b0;
  logic         reset;
  logic         sel_m0, wr_m0, sel_m1, wr_m1;
  logic [10:0]  addr_m0, addr_m1;
  logic [31:0]  wd_m0, wd_m1;
  logic [3:0]   st_m0, st_m1;
  logic         wrrdy_m0, rdvalid_m0, err_m0, wrrdy_m1, rdvalid_m1, err_m1;
  logic [31:0]  rd_m0, rd_m1;
  logic [3:0]   ctrlSel;
  logic         ctrlWr;
  logic [10:0]  ctrlAddr;
  logic [31:0]  ctrlWrData;
  logic [3:0]   ctrlWrStrbs;
  logic [3:0]   wr_s, rv_s;
  logic [127:0] rd_s;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  ctrl_if_arb_mux dut (
    .clock(clock), .reset(reset),
    .ctrlSel_m0(sel_m0), .ctrlWr_m0(wr_m0), .ctrlAddr_m0(addr_m0),
    .ctrlWrData_m0(wd_m0), .ctrlWrStrbs_m0(st_m0),
    .ctrlWrRdy_m0(wrrdy_m0), .ctrlRdValid_m0(rdvalid_m0),
    .ctrlRdData_m0(rd_m0), .ctrlErr_m0(err_m0),
    .ctrlSel_m1(sel_m1), .ctrlWr_m1(wr_m1), .ctrlAddr_m1(addr_m1),
    .ctrlWrData_m1(wd_m1), .ctrlWrStrbs_m1(st_m1),
    .ctrlWrRdy_m1(wrrdy_m1), .ctrlRdValid_m1(rdvalid_m1),
    .ctrlRdData_m1(rd_m1), .ctrlErr_m1(err_m1),
    .ctrlSel(ctrlSel), .ctrlWr(ctrlWr), .ctrlAddr(ctrlAddr),
    .ctrlWrData(ctrlWrData), .ctrlWrStrbs(ctrlWrStrbs),
    .ctrlWrRdy_s(wr_s), .ctrlRdValid_s(rv_s), .ctrlRdData_s(rd_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int m, input logic on, input logic wr, input logic [10:0] a,
                         input logic [31:0] wd, input logic [3:0] st);
    if (m == 0) begin
      sel_m0 = on; wr_m0 = wr; addr_m0 = a; wd_m0 = wd; st_m0 = st;
    end else begin
      sel_m1 = on; wr_m1 = wr; addr_m1 = a; wd_m1 = wd; st_m1 = st;
    end
  endtask

  task automatic clear_slaves();
    wr_s = 4'b0;
    rv_s = 4'b0;
    rd_s = '0;
  endtask

  // dly < 0 means the slave never answers
  task automatic txn(input string tag, input int m, input logic wr, input logic [10:0] a,
                     input logic [31:0] wd, input logic [3:0] st, input int dly, input int slv,
                     input logic [31:0] rd, input logic noise);
    int          cycles;
    logic        tmo;
    logic [3:0]  oh;
    logic [31:0] exp_rd;
    tmo = (dly < 0);
    oh = 4'b0001 << slv;
    exp_rd = tmo ? 32'h0 : rd;
    @(negedge clock);
    set_req(m, 1'b1, wr, a, wd, st);
    @(negedge clock);
    cycles = 0;
    while (ctrlSel != 4'b0 && cycles < 40) begin
      check({tag, ":sel"}, ctrlSel, oh);
      check({tag, ":addr"}, ctrlAddr, a);
      check({tag, ":wr"}, ctrlWr, wr);
      if (wr) begin
        check({tag, ":wdata"}, ctrlWrData, wd);
        check({tag, ":strb"}, ctrlWrStrbs, st);
      end
      clear_slaves();
      rd_s = {4{32'hDEAD_BEEF}};
      if (noise) begin
        rv_s = ~oh;
        wr_s = ~oh;
      end
      if (cycles == dly) begin
        if (wr) wr_s[slv] = 1'b1;
        else    rv_s[slv] = 1'b1;
        rd_s[slv*32 +: 32] = rd;
      end
      cycles++;
      @(negedge clock);
    end
    clear_slaves();
    check({tag, ":issue_cycles"}, cycles, tmo ? 16 : dly + 1);
    if (m == 0) begin
      check({tag, ":wrrdy"}, wrrdy_m0, wr);
      check({tag, ":rdvalid"}, rdvalid_m0, !wr);
      check({tag, ":err"}, err_m0, tmo);
      if (!wr) check({tag, ":rdata"}, rd_m0, exp_rd);
      check({tag, ":other_pulse"}, {wrrdy_m1, rdvalid_m1, err_m1}, 3'b000);
    end else begin
      check({tag, ":wrrdy"}, wrrdy_m1, wr);
      check({tag, ":rdvalid"}, rdvalid_m1, !wr);
      check({tag, ":err"}, err_m1, tmo);
      if (!wr) check({tag, ":rdata"}, rd_m1, exp_rd);
      check({tag, ":other_pulse"}, {wrrdy_m0, rdvalid_m0, err_m0}, 3'b000);
    end
    set_req(m, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    @(negedge clock);
    check({tag, ":pulse_end"}, {wrrdy_m0, rdvalid_m0, err_m0, wrrdy_m1, rdvalid_m1, err_m1}, 6'b0);
    if (!wr) check({tag, ":rdata_hold"}, (m == 0) ? rd_m0 : rd_m1, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] baddr [4];
    logic [31:0] bdata [4];
    int          order [3];
    baddr = '{11'h003, 11'h05F, 11'h45F, 11'h7FF};
    bdata = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444};
    order = '{0, 1, 0};

    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    clear_slaves();
    repeat (3) @(negedge clock);
    check("rst:sel", ctrlSel, 4'b0);
    check("rst:pulses", {wrrdy_m0, rdvalid_m0, err_m0, wrrdy_m1, rdvalid_m1, err_m1}, 6'b0);
    check("rst:rdata", {rd_m0, rd_m1}, 64'h0);
    check("rst:slvside", {ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs}, 48'h0);
    reset = 1'b0;

    txn("m0_rd0", 0, 1'b0, 11'h000, 32'h0, 4'h0, 0, 0, 32'h1234_5678, 1'b0);
    txn("m1_wr460", 1, 1'b1, 11'h460, 32'hA5A5_A5A5, 4'hF, 2, 3, 32'h0, 1'b0);

    // pointer is back on m0 here: alternating grants expected
    set_req(0, 1'b1, 1'b1, 11'h060, 32'h1111_2222, 4'h3);
    set_req(1, 1'b1, 1'b0, 11'h004, 32'h0, 4'h0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      check("rr:sel", ctrlSel, (order[t] == 0) ? 4'b0100 : 4'b0010);
      if (order[t] == 0) begin
        wr_s = 4'b0100;
      end else begin
        rv_s = 4'b0010;
        rd_s[32 +: 32] = 32'hCAFE_0000 + t;
      end
      @(negedge clock);
      clear_slaves();
      check("rr:wrrdy_m0", wrrdy_m0, order[t] == 0);
      check("rr:rdvalid_m1", rdvalid_m1, order[t] == 1);
      if (order[t] == 1) check("rr:rdata_m1", rd_m1, 32'hCAFE_0000 + t);
      if (t == 2) begin
        set_req(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
      end
      @(negedge clock);
      check("rr:idle_sel", ctrlSel, 4'b0);
    end

    txn("m0_tmo", 0, 1'b0, 11'h100, 32'h0, 4'h0, -1, 2, 32'h0, 1'b0);

    for (int i = 0; i < 4; i++)
      txn($sformatf("bnd%0d", i), 0, 1'b0, baddr[i], 32'h0, 4'h0, 2, i, bdata[i], 1'b1);

    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 11'h100, 32'h0, 4'h0);
    @(negedge clock);
    check("mid_rst:issue", ctrlSel, 4'b0100);
    rv_s = 4'b0100;
    rd_s[64 +: 32] = 32'h7777_7777;
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst:sel", ctrlSel, 4'b0);
    check("mid_rst:pulses", {wrrdy_m0, rdvalid_m0, err_m0, wrrdy_m1, rdvalid_m1, err_m1}, 6'b0);
    check("mid_rst:rdata", {rd_m0, rd_m1}, 64'h0);
    check("mid_rst:slvside", {ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs}, 48'h0);
    reset = 1'b0;
    clear_slaves();
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    @(negedge clock);
    check("post_rst:no_pulse", {wrrdy_m0, rdvalid_m0, ctrlSel}, 6'b0);

    set_req(0, 1'b1, 1'b0, 11'h000, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 11'h004, 32'h0, 4'h0);
    @(negedge clock);
    check("post_rst:m0_first", ctrlSel, 4'b0001);
    rv_s = 4'b0001;
    rd_s[0 +: 32] = 32'h0BAD_F00D;
    @(negedge clock);
    clear_slaves();
    check("post_rst:rdvalid_m0", rdvalid_m0, 1'b1);
    check("post_rst:rdata_m0", rd_m0, 32'h0BAD_F00D);
    check("post_rst:rdvalid_m1", rdvalid_m1, 1'b0);
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    @(negedge clock);
    @(negedge clock);
    check("post_rst:m1_next", ctrlSel, 4'b0010);
    rv_s = 4'b0010;
    rd_s[32 +: 32] = 32'h5151_5151;
    @(negedge clock);
    clear_slaves();
    check("post_rst:rdvalid_m1b", rdvalid_m1, 1'b1);
    check("post_rst:rdata_m1", rd_m1, 32'h5151_5151);
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
